// File: rtl/qupls_alu_steer_pkg.sv
// ----------------------------------------------------------------------------
// QuplsPkg: shared types and classification helpers for the ALU steering stage.
//   alu_class_t   : per-lane steering class (CLS_NONE / CLS_ANY / CLS_ALU0)
//   opcode_t      : major opcode field of a decoded instruction
//   funct_t       : function field used by OP_R2 register-register ops
//   instruction_t : decoded instruction carried through the stage
//   fnAluClass    : opcode/funct -> alu_class_t
//   fnIsDivide    : opcode/funct -> long-latency divide/modulo flag
// ----------------------------------------------------------------------------
package QuplsPkg;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_ANY  = 2'd1,
        CLS_ALU0 = 2'd2
    } alu_class_t;

    typedef enum logic [5:0] {
        OP_NOP   = 6'd0,
        OP_R2    = 6'd2,
        OP_ADDI  = 6'd4,
        OP_CMPI  = 6'd5,
        OP_ANDI  = 6'd8,
        OP_ORI   = 6'd9,
        OP_XORI  = 6'd10,
        OP_MULI  = 6'd12,
        OP_MULUI = 6'd13,
        OP_DIVI  = 6'd14,
        OP_DIVUI = 6'd15,
        OP_CSR   = 6'd16,
        OP_BSR   = 6'd20,
        OP_JSR   = 6'd21,
        OP_PRED  = 6'd24,
        OP_BCC   = 6'd28,
        OP_LOAD  = 6'd32,
        OP_STORE = 6'd40
    } opcode_t;

    typedef enum logic [4:0] {
        F_ADD    = 5'd0,
        F_SUB    = 5'd1,
        F_AND    = 5'd2,
        F_OR     = 5'd3,
        F_XOR    = 5'd4,
        F_SLT    = 5'd5,
        F_MUL    = 5'd8,
        F_MULU   = 5'd9,
        F_MULSU  = 5'd10,
        F_MULW   = 5'd11,
        F_MULUW  = 5'd12,
        F_MULSUW = 5'd13,
        F_DIV    = 5'd16,
        F_DIVU   = 5'd17,
        F_DIVSU  = 5'd18,
        F_MOD    = 5'd19,
        F_MODU   = 5'd20,
        F_MODSU  = 5'd21
    } funct_t;

    typedef struct packed {
        opcode_t     opcode;
        funct_t      funct;
        logic [5:0]  rd;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [10:0] imm;
    } instruction_t;

    function automatic alu_class_t fnAluClass(input opcode_t op, input funct_t fn);
        alu_class_t cls;
        cls = CLS_NONE;
        case (op)
            OP_R2: begin
                // Multiply/divide hardware only exists on ALU 0.
                case (fn)
                    F_MUL, F_MULU, F_MULSU, F_MULW, F_MULUW, F_MULSUW,
                    F_DIV, F_DIVU, F_DIVSU, F_MOD, F_MODU, F_MODSU: cls = CLS_ALU0;
                    default: cls = CLS_ANY;
                endcase
            end
            OP_CSR, OP_BSR, OP_JSR, OP_MULI, OP_MULUI,
            OP_DIVI, OP_DIVUI, OP_PRED: cls = CLS_ALU0;
            OP_ADDI, OP_CMPI, OP_ANDI, OP_ORI, OP_XORI: cls = CLS_ANY;
            default: cls = CLS_NONE;
        endcase
        return cls;
    endfunction

    function automatic logic fnIsDivide(input opcode_t op, input funct_t fn);
        logic is_div;
        is_div = 1'b0;
        case (op)
            OP_R2: begin
                case (fn)
                    F_DIV, F_DIVU, F_DIVSU, F_MOD, F_MODU, F_MODSU: is_div = 1'b1;
                    default: is_div = 1'b0;
                endcase
            end
            OP_DIVI, OP_DIVUI: is_div = 1'b1;
            default: is_div = 1'b0;
        endcase
        return is_div;
    endfunction

endpackage

// File: rtl/qupls_alu_steer_if.sv
// ----------------------------------------------------------------------------
// qupls_alu_steer_if: handshake/bus bundle of the ALU steering stage.
//   in_valid/in_ready/instr            : decoded group from decode
//   out_valid/out_ready                : steered group to the issue queues
//   out_instr/out_cls/out_alu          : registered group, class and ALU index
//   alu0_held                          : ALU 0 fence active
//   slave  modport : the steering stage
//   master modport : the environment driving it
// ----------------------------------------------------------------------------
interface qupls_alu_steer_if #(
    parameter int NLANE = 4,
    parameter int NALU  = 2
);
    import QuplsPkg::*;

    localparam int AW = $clog2(NALU);

    logic                           in_valid;
    logic                           in_ready;
    instruction_t [NLANE-1:0]       instr;
    logic                           out_valid;
    logic                           out_ready;
    instruction_t [NLANE-1:0]       out_instr;
    alu_class_t   [NLANE-1:0]       out_cls;
    logic         [NLANE-1:0][AW-1:0] out_alu;
    logic                           alu0_held;

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, out_instr, out_cls, out_alu, alu0_held
    );

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, out_instr, out_cls, out_alu, alu0_held
    );

endinterface

// File: rtl/qupls_alu_steer_classify.sv
// ----------------------------------------------------------------------------
// qupls_alu_classify: combinational per-lane classifier.
//   instr_i : decoded instruction
//   cls_o   : steering class of the lane
//   div_o   : lane is a divide/modulo (triggers the ALU 0 fence)
// ----------------------------------------------------------------------------
module qupls_alu_classify
    import QuplsPkg::*;
(
    input  instruction_t instr_i,
    output alu_class_t   cls_o,
    output logic         div_o
);
    assign cls_o = fnAluClass(instr_i.opcode, instr_i.funct);
    assign div_o = fnIsDivide(instr_i.opcode, instr_i.funct);

    // Register and immediate fields do not affect steering.
    logic unused_fields;
    assign unused_fields = ^{instr_i.rd, instr_i.rs1, instr_i.rs2, instr_i.imm};

endmodule

// File: rtl/qupls_alu_steer.sv
// ----------------------------------------------------------------------------
// qupls_alu_steer: steers each decode lane to an integer ALU.
//   clk      : clock
//   rst      : asynchronous active-high reset
//   steer_if : qupls_alu_steer_if.slave (input group, registered output group)
// ALU0-only ops are pinned to ALU 0 and, when present, remove ALU 0 from the
// round-robin set for the other lanes. Optional macro QUPLS_ALU0_FENCE_EN adds
// a hold counter that withholds ALU 0 for DIV_HOLD cycles after a divide.
// ----------------------------------------------------------------------------
module qupls_alu_steer
    import QuplsPkg::*;
#(
    parameter int NLANE    = 4,
    parameter int NALU     = 2,
    parameter int DIV_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    qupls_alu_steer_if.slave steer_if
);
    localparam int AW = $clog2(NALU);
    typedef logic [AW-1:0] alu_idx_t;

    alu_class_t [NLANE-1:0] lane_cls;
    logic       [NLANE-1:0] lane_div;
    alu_idx_t   [NLANE-1:0] lane_alu;
    logic       [NALU-1:0]  elig;
    logic                   grp_alu0, grp_any, grp_div, hold_block;
    logic                   accept, in_ready;
    alu_idx_t               ptr, rr_d, rr_q;

    logic                   out_valid_q;
    instruction_t [NLANE-1:0] out_instr_q;
    alu_class_t   [NLANE-1:0] out_cls_q;
    alu_idx_t     [NLANE-1:0] out_alu_q;

    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        qupls_alu_classify u_classify (
            .instr_i (steer_if.instr[g]),
            .cls_o   (lane_cls[g]),
            .div_o   (lane_div[g])
        );
    end

    // First eligible ALU at or above start, wrapping to the lowest eligible.
    function automatic alu_idx_t first_elig(input logic [NALU-1:0] mask, input int start);
        alu_idx_t ge_idx, any_idx;
        logic     ge_found;
        ge_idx   = '0;
        any_idx  = '0;
        ge_found = 1'b0;
        for (int i = NALU - 1; i >= 0; i--) begin
            if (mask[i]) begin
                any_idx = alu_idx_t'(i);
                if (i >= start) begin
                    ge_idx   = alu_idx_t'(i);
                    ge_found = 1'b1;
                end
            end
        end
        return ge_found ? ge_idx : any_idx;
    endfunction

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        grp_alu0 = 1'b0;
        grp_any  = 1'b0;
        grp_div  = 1'b0;
        for (int l = 0; l < NLANE; l++) begin
            if (lane_cls[l] == CLS_ALU0) grp_alu0 = 1'b1;
            if (lane_cls[l] == CLS_ANY)  grp_any  = 1'b1;
            if (lane_div[l])             grp_div  = 1'b1;
        end

        elig = '1;
        if (grp_alu0 || hold_block) elig[0] = 1'b0;

        // ptr always holds the next ALU to hand out; after the last ANY lane
        // it is exactly the new round-robin position.
        ptr = first_elig(elig, int'(rr_q));
        for (int l = 0; l < NLANE; l++) begin
            lane_alu[l] = '0;
            if (lane_cls[l] == CLS_ANY) begin
                lane_alu[l] = ptr;
                ptr         = first_elig(elig, int'(ptr) + 1);
            end
        end
        rr_d = grp_any ? ptr : rr_q;
    end

    assign in_ready = !out_valid_q || steer_if.out_ready;
    assign accept   = steer_if.in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_alu_q   <= '0;
            rr_q        <= alu_idx_t'(1);
            for (int l = 0; l < NLANE; l++) out_cls_q[l] <= CLS_NONE;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_instr_q <= steer_if.instr;
            out_cls_q   <= lane_cls;
            out_alu_q   <= lane_alu;
            rr_q        <= rr_d;
        end else if (steer_if.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef QUPLS_ALU0_FENCE_EN
    logic [5:0] hold_q, hold_d;

    // A new divide reloads the fence even if it is already counting.
    always_comb begin
        hold_d = hold_q;
        if (accept && grp_div)  hold_d = 6'(DIV_HOLD);
        else if (hold_q != '0)  hold_d = hold_q - 6'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_q <= '0;
        else     hold_q <= hold_d;
    end

    assign hold_block         = (hold_q != '0);
    assign steer_if.alu0_held = hold_block;
`else
    assign hold_block         = 1'b0;
    assign steer_if.alu0_held = 1'b0;

    logic unused_fence;
    assign unused_fence = grp_div ^ (DIV_HOLD > 0);
`endif

    assign steer_if.in_ready  = in_ready;
    assign steer_if.out_valid = out_valid_q;
    assign steer_if.out_instr = out_instr_q;
    assign steer_if.out_cls   = out_cls_q;
    assign steer_if.out_alu   = out_alu_q;

endmodule

// File: tb/tb_qupls_alu_steer.sv
// ----------------------------------------------------------------------------
// tb_qupls_alu_steer: directed bench for qupls_alu_steer (NLANE=4, NALU=2,
// DIV_HOLD=3). Expectations for the ALU 0 fence follow QUPLS_ALU0_FENCE_EN.
// ----------------------------------------------------------------------------
module tb_qupls_alu_steer;
    import QuplsPkg::*;

    localparam int NLANE    = 4;
    localparam int NALU     = 2;
    localparam int DIV_HOLD = 3;
`ifdef QUPLS_ALU0_FENCE_EN
    localparam bit FENCE = 1'b1;
`else
    localparam bit FENCE = 1'b0;
`endif

    typedef instruction_t [3:0] grp_t;
    typedef logic [3:0][0:0]    alu_vec_t;
    typedef alu_class_t [3:0]   cls_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    qupls_alu_steer_if #(.NLANE(NLANE), .NALU(NALU)) bus ();

    qupls_alu_steer #(.NLANE(NLANE), .NALU(NALU), .DIV_HOLD(DIV_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .steer_if (bus)
    );

    always #5 clk = ~clk;

    function automatic instruction_t mk(input opcode_t op, input funct_t fn, input int tag);
        instruction_t r;
        r.opcode = op;
        r.funct  = fn;
        r.rd     = 6'(tag);
        r.rs1    = 6'(tag + 1);
        r.rs2    = 6'(tag + 2);
        r.imm    = 11'(tag * 3);
        return r;
    endfunction

    function automatic grp_t grp(input instruction_t i0, i1, i2, i3);
        grp_t g;
        g[0] = i0; g[1] = i1; g[2] = i2; g[3] = i3;
        return g;
    endfunction

    function automatic alu_vec_t alu4(input int a0, a1, a2, a3);
        alu_vec_t v;
        v[0] = 1'(a0); v[1] = 1'(a1); v[2] = 1'(a2); v[3] = 1'(a3);
        return v;
    endfunction

    function automatic cls_vec_t cls4(input alu_class_t c0, c1, c2, c3);
        cls_vec_t v;
        v[0] = c0; v[1] = c1; v[2] = c2; v[3] = c3;
        return v;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input grp_t g);
        bus.instr    = g;
        bus.in_valid = 1'b1;
        step();
    endtask

    grp_t g1, g2, g3, g4, g5, g6, g7, g8, g9, gs1, gs2, gr1, gr2, gr3;

    initial begin
        g1  = grp(mk(OP_R2, F_ADD, 1), mk(OP_ADDI, F_ADD, 2), mk(OP_R2, F_SUB, 3), mk(OP_XORI, F_ADD, 4));
        g2  = grp(mk(OP_R2, F_MUL, 5), mk(OP_R2, F_ADD, 6), mk(OP_ANDI, F_ADD, 7), mk(OP_CSR, F_ADD, 8));
        g3  = grp(mk(OP_ORI, F_ADD, 9), mk(OP_CMPI, F_ADD, 10), mk(OP_R2, F_ADD, 11), mk(OP_R2, F_SUB, 12));
        g4  = grp(mk(OP_R2, F_ADD, 13), mk(OP_R2, F_ADD, 14), mk(OP_R2, F_ADD, 15), mk(OP_NOP, F_ADD, 0));
        g5  = grp(mk(OP_LOAD, F_ADD, 16), mk(OP_STORE, F_ADD, 17), mk(OP_BCC, F_ADD, 18), mk(OP_NOP, F_ADD, 0));
        g6  = grp(mk(OP_R2, F_ADD, 19), mk(OP_ADDI, F_ADD, 20), mk(OP_NOP, F_ADD, 0), mk(OP_NOP, F_ADD, 0));
        g7  = grp(mk(OP_DIVI, F_ADD, 21), mk(OP_R2, F_ADD, 22), mk(OP_NOP, F_ADD, 0), mk(OP_NOP, F_ADD, 0));
        g8  = grp(mk(OP_R2, F_ADD, 23), mk(OP_R2, F_ADD, 24), mk(OP_R2, F_ADD, 25), mk(OP_R2, F_ADD, 26));
        g9  = grp(mk(OP_R2, F_ADD, 27), mk(OP_R2, F_SUB, 28), mk(OP_NOP, F_ADD, 0), mk(OP_NOP, F_ADD, 0));
        gs1 = grp(mk(OP_ADDI, F_ADD, 29), mk(OP_LOAD, F_ADD, 30), mk(OP_MULI, F_ADD, 31), mk(OP_R2, F_ADD, 32));
        gs2 = grp(mk(OP_R2, F_ADD, 33), mk(OP_R2, F_ADD, 34), mk(OP_R2, F_ADD, 35), mk(OP_R2, F_ADD, 36));
        gr1 = grp(mk(OP_R2, F_ADD, 37), mk(OP_R2, F_ADD, 38), mk(OP_R2, F_ADD, 39), mk(OP_NOP, F_ADD, 0));
        gr2 = grp(mk(OP_R2, F_DIV, 40), mk(OP_NOP, F_ADD, 0), mk(OP_NOP, F_ADD, 0), mk(OP_NOP, F_ADD, 0));
        gr3 = grp(mk(OP_R2, F_ADD, 41), mk(OP_R2, F_ADD, 42), mk(OP_NOP, F_ADD, 0), mk(OP_NOP, F_ADD, 0));

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.instr     = '0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_instr", bus.out_instr, '0);
        check("rst_out_cls",   bus.out_cls, cls4(CLS_NONE, CLS_NONE, CLS_NONE, CLS_NONE));
        check("rst_out_alu",   bus.out_alu, '0);
        check("rst_alu0_held", bus.alu0_held, 1'b0);
        check("rst_in_ready",  bus.in_ready, 1'b1);
        rst = 1'b0;

        // Four ANY lanes alternate starting from rr = 1.
        send(g1);
        check("g1_valid", bus.out_valid, 1'b1);
        check("g1_instr", bus.out_instr, g1);
        check("g1_cls",   bus.out_cls, cls4(CLS_ANY, CLS_ANY, CLS_ANY, CLS_ANY));
        check("g1_alu",   bus.out_alu, alu4(1, 0, 1, 0));

        // ALU0-only lanes pin to 0 and push ANY lanes off ALU 0.
        send(g2);
        check("g2_valid", bus.out_valid, 1'b1);
        check("g2_cls",   bus.out_cls, cls4(CLS_ALU0, CLS_ANY, CLS_ANY, CLS_ALU0));
        check("g2_alu",   bus.out_alu, alu4(0, 1, 1, 0));

        send(g3);
        check("g3_alu_rr1", bus.out_alu, alu4(1, 0, 1, 0));

        // Three ANY lanes leave rr at 0.
        send(g4);
        check("g4_cls", bus.out_cls, cls4(CLS_ANY, CLS_ANY, CLS_ANY, CLS_NONE));
        check("g4_alu", bus.out_alu, alu4(1, 0, 1, 0));

        send(g5);
        check("g5_cls", bus.out_cls, cls4(CLS_NONE, CLS_NONE, CLS_NONE, CLS_NONE));
        check("g5_alu", bus.out_alu, alu4(0, 0, 0, 0));

        // rr still 0 after the non-ALU group.
        send(g6);
        check("g6_alu_rr0", bus.out_alu, alu4(0, 1, 0, 0));

        bus.in_valid = 1'b0;
        step();
        check("drain_valid", bus.out_valid, 1'b0);

        #2 rst = 1'b1;
        #2 rst = 1'b0;

        // Divide group: fence for DIV_HOLD groups when compiled in.
        send(g7);
        check("g7_cls",  bus.out_cls, cls4(CLS_ALU0, CLS_ANY, CLS_NONE, CLS_NONE));
        check("g7_alu",  bus.out_alu, alu4(0, 1, 0, 0));
        check("g7_held", bus.alu0_held, FENCE);
        send(g8);
        check("f1_alu",  bus.out_alu, FENCE ? alu4(1, 1, 1, 1) : alu4(1, 0, 1, 0));
        check("f1_held", bus.alu0_held, FENCE);
        send(g8);
        check("f2_alu",  bus.out_alu, FENCE ? alu4(1, 1, 1, 1) : alu4(1, 0, 1, 0));
        check("f2_held", bus.alu0_held, FENCE);
        send(g8);
        check("f3_alu",  bus.out_alu, FENCE ? alu4(1, 1, 1, 1) : alu4(1, 0, 1, 0));
        check("f3_held", bus.alu0_held, 1'b0);
        send(g9);
        check("g9_alu",  bus.out_alu, alu4(1, 0, 0, 0));

        // Back-pressure: output frozen, next group waits for out_ready.
        send(gs1);
        check("gs1_cls", bus.out_cls, cls4(CLS_ANY, CLS_NONE, CLS_ALU0, CLS_ANY));
        check("gs1_alu", bus.out_alu, alu4(1, 0, 0, 1));
        bus.out_ready = 1'b0;
        bus.instr     = gs2;
        #1;
        check("stall_in_ready", bus.in_ready, 1'b0);
        for (int c = 0; c < 2; c++) begin
            step();
            check("stall_valid",    bus.out_valid, 1'b1);
            check("stall_instr",    bus.out_instr, gs1);
            check("stall_alu",      bus.out_alu, alu4(1, 0, 0, 1));
            check("stall_in_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("release_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        check("gs2_instr", bus.out_instr, gs2);
        check("gs2_alu",   bus.out_alu, alu4(1, 0, 1, 0));

        // Move rr to 0 and arm the fence, then reset during a stall.
        send(gr1);
        check("gr1_alu", bus.out_alu, alu4(1, 0, 1, 0));
        send(gr2);
        check("gr2_cls",  bus.out_cls, cls4(CLS_ALU0, CLS_NONE, CLS_NONE, CLS_NONE));
        check("gr2_alu",  bus.out_alu, alu4(0, 0, 0, 0));
        check("gr2_held", bus.alu0_held, FENCE);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("pre_rst_valid", bus.out_valid, 1'b1);
        check("pre_rst_held",  bus.alu0_held, FENCE);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid",    bus.out_valid, 1'b0);
        check("async_rst_held",     bus.alu0_held, 1'b0);
        check("async_rst_alu",      bus.out_alu, '0);
        check("async_rst_instr",    bus.out_instr, '0);
        check("async_rst_in_ready", bus.in_ready, 1'b1);
        #2 rst = 1'b0;
        bus.out_ready = 1'b1;

        // rr back at 1 and no leftover fence.
        send(gr3);
        check("post_rst_alu",  bus.out_alu, alu4(1, 0, 0, 0));
        check("post_rst_held", bus.alu0_held, 1'b0);
        bus.in_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
